// File: rtl/cx_pkg.sv
// cx_pkg: shared widths, FSM states and complex operand type for the cx_* datapath blocks.
package cx_pkg;

    localparam int CX_WIDTH = 32;
    localparam int CX_FRAC  = 0;

    function automatic int nw_of(input int width, input int frac);
        return 2 * width + 1 + frac;
    endfunction

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    typedef struct packed {
        logic signed [CX_WIDTH-1:0] re;
        logic signed [CX_WIDTH-1:0] im;
    } cx_t;

endpackage

// File: rtl/serial_udiv_step.sv
// serial_udiv_step: one restoring long-division step (shift in a dividend bit, subtract if it fits).
module serial_udiv_step #(
    parameter int RW = 66
) (
    input  logic [RW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [RW-1:0] div_i,
    output logic [RW-1:0] rem_o,
    output logic          q_o
);

    logic [RW:0] sh;

    assign sh    = {rem_i, bit_i};
    assign q_o   = sh >= {1'b0, div_i};
    assign rem_o = q_o ? RW'(sh - {1'b0, div_i}) : RW'(sh);

endmodule

// File: rtl/cx_divider.sv
// cx_divider: sequential signed complex divider, one multiply cycle then NW-cycle restoring division.
module cx_divider
    import cx_pkg::*;
#(
    parameter int WIDTH = CX_WIDTH,
    parameter int FRAC  = CX_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num_re,
    input  logic [WIDTH-1:0] num_im,
    input  logic [WIDTH-1:0] den_re,
    input  logic [WIDTH-1:0] den_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot_re,
    output logic [WIDTH-1:0] quot_im,
    output logic             div_by_zero
);

    localparam int PW = 2 * WIDTH + 1;
    localparam int NW = nw_of(WIDTH, FRAC);
    localparam int RW = PW + 1;
    localparam int CW = $clog2(NW);

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, e_q, e_d;
    logic [NW-1:0]           dre_q, dre_d, dim_q, dim_d;
    logic [RW-1:0]           rre_q, rre_d, rim_q, rim_d, dv_q, dv_d, rre_n, rim_n;
    logic                    sre_q, sre_d, sim_q, sim_d, qb_re, qb_im;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        qre_q, qre_d, qim_q, qim_d, low_re, low_im;
    logic                    dbz_q, dbz_d;
    logic signed [PW-1:0]    a_x, b_x, c_x, e_x, n_re, n_im, d_w;
    logic signed [NW-1:0]    nre_w, nim_w;
    logic [NW-1:0]           mag_re, mag_im;

    // Products, sums and denominator are formed at full 2*WIDTH+1 precision so nothing overflows.
    assign a_x    = PW'(a_q);
    assign b_x    = PW'(b_q);
    assign c_x    = PW'(c_q);
    assign e_x    = PW'(e_q);
    assign n_re   = a_x * c_x + b_x * e_x;
    assign n_im   = b_x * c_x - a_x * e_x;
    assign d_w    = c_x * c_x + e_x * e_x;
    assign nre_w  = NW'(n_re);
    assign nim_w  = NW'(n_im);
    assign mag_re = nre_w[NW-1] ? -nre_w : nre_w;
    assign mag_im = nim_w[NW-1] ? -nim_w : nim_w;

    // The dividend register doubles as the quotient register: quotient bits enter at the LSB.
    assign low_re = {dre_q[WIDTH-2:0], qb_re};
    assign low_im = {dim_q[WIDTH-2:0], qb_im};

    serial_udiv_step #(.RW(RW)) u_step_re (
        .rem_i(rre_q), .bit_i(dre_q[NW-1]), .div_i(dv_q), .rem_o(rre_n), .q_o(qb_re)
    );

    serial_udiv_step #(.RW(RW)) u_step_im (
        .rem_i(rim_q), .bit_i(dim_q[NW-1]), .div_i(dv_q), .rem_o(rim_n), .q_o(qb_im)
    );

    assign in_ready    = state_q == IDLE;
    assign out_valid   = state_q == DONE;
    assign quot_re     = qre_q;
    assign quot_im     = qim_q;
    assign div_by_zero = dbz_q;

    // Next-state and datapath control for the accept / multiply / divide / present sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        e_d     = e_q;
        dre_d   = dre_q;
        dim_d   = dim_q;
        rre_d   = rre_q;
        rim_d   = rim_q;
        dv_d    = dv_q;
        sre_d   = sre_q;
        sim_d   = sim_q;
        cnt_d   = cnt_q;
        qre_d   = qre_q;
        qim_d   = qim_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = num_re;
                b_d     = num_im;
                c_d     = den_re;
                e_d     = den_im;
                state_d = MUL;
            end
            MUL: if (d_w == '0) begin
                qre_d   = '0;
                qim_d   = '0;
                dbz_d   = 1'b1;
                state_d = DONE;
            end else begin
                dre_d   = mag_re << FRAC;
                dim_d   = mag_im << FRAC;
                rre_d   = '0;
                rim_d   = '0;
                dv_d    = RW'(d_w);
                sre_d   = n_re[PW-1];
                sim_d   = n_im[PW-1];
                cnt_d   = CW'(NW - 1);
                state_d = DIV;
            end
            DIV: begin
                rre_d = rre_n;
                rim_d = rim_n;
                dre_d = {dre_q[NW-2:0], qb_re};
                dim_d = {dim_q[NW-2:0], qb_im};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    qre_d   = sre_q ? -low_re : low_re;
                    qim_d   = sim_q ? -low_im : low_im;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            e_q     <= '0;
            dre_q   <= '0;
            dim_q   <= '0;
            rre_q   <= '0;
            rim_q   <= '0;
            dv_q    <= '0;
            sre_q   <= 1'b0;
            sim_q   <= 1'b0;
            cnt_q   <= '0;
            qre_q   <= '0;
            qim_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            e_q     <= e_d;
            dre_q   <= dre_d;
            dim_q   <= dim_d;
            rre_q   <= rre_d;
            rim_q   <= rim_d;
            dv_q    <= dv_d;
            sre_q   <= sre_d;
            sim_q   <= sim_d;
            cnt_q   <= cnt_d;
            qre_q   <= qre_d;
            qim_q   <= qim_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: tb/tb_cx_divider.sv
// tb_cx_divider: randomized and directed checks of cx_divider against a wide-integer reference model.
module tb_cx_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, in_valid_f = 1'b0, out_ready_f = 1'b0;
    logic [31:0] num_re = '0, num_im = '0, den_re = '0, den_im = '0;
    logic        in_ready, out_valid, div_by_zero, in_ready_f, out_valid_f, dbz_f;
    logic [31:0] quot_re, quot_im, qre_f, qim_f;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    cx_divider #(.WIDTH(32), .FRAC(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .num_re(num_re), .num_im(num_im), .den_re(den_re), .den_im(den_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .quot_re(quot_re), .quot_im(quot_im), .div_by_zero(div_by_zero)
    );

    cx_divider #(.WIDTH(32), .FRAC(16)) dut_f (
        .clk(clk), .rst(rst), .in_valid(in_valid_f), .in_ready(in_ready_f),
        .num_re(num_re), .num_im(num_im), .den_re(den_re), .den_im(den_im),
        .out_valid(out_valid_f), .out_ready(out_ready_f),
        .quot_re(qre_f), .quot_im(qim_f), .div_by_zero(dbz_f)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Complex division straight from the formula, in 128-bit arithmetic.
    function automatic void model(input logic signed [31:0] a, b, c, e, input int frac,
                                  output logic [31:0] qr, output logic [31:0] qi, output bit z);
        logic signed [127:0] nr, ni, d, mr, mi;
        nr = 128'(a) * 128'(c) + 128'(b) * 128'(e);
        ni = 128'(b) * 128'(c) - 128'(a) * 128'(e);
        d  = 128'(c) * 128'(c) + 128'(e) * 128'(e);
        z  = d == 0;
        qr = '0;
        qi = '0;
        if (!z) begin
            mr = ((nr < 0) ? -nr : nr) << frac;
            mi = ((ni < 0) ? -ni : ni) << frac;
            mr = mr / d;
            mi = mi / d;
            mr = (nr < 0) ? -mr : mr;
            mi = (ni < 0) ? -mi : mi;
            qr = mr[31:0];
            qi = mi[31:0];
        end
    endfunction

    // Counts edges from the accept edge (inclusive) until out_valid; operands are withdrawn after it.
    task automatic wait_ov(input bit f, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            in_valid   = 1'b0;
            in_valid_f = 1'b0;
            lat++;
        end while (!(f ? out_valid_f : out_valid) && lat < 300);
    endtask

    task automatic run(input logic [31:0] a, b, c, e, input string tag);
        logic [31:0] er, ei;
        bit          ez;
        int          lat;
        model(a, b, c, e, 0, er, ei, ez);
        @(negedge clk);
        num_re = a; num_im = b; den_re = c; den_im = e;
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        wait_ov(1'b0, lat);
        check({tag, "_lat"}, 64'(lat), ez ? 64'd2 : 64'd67);
        check({tag, "_re"}, 64'(quot_re), 64'(er));
        check({tag, "_im"}, 64'(quot_im), 64'(ei));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ack"}, 64'({in_ready, out_valid}), 64'b10);
    endtask

    task automatic run_f(input logic [31:0] a, b, c, e, input string tag);
        logic [31:0] er, ei;
        bit          ez;
        int          lat;
        model(a, b, c, e, 16, er, ei, ez);
        @(negedge clk);
        num_re = a; num_im = b; den_re = c; den_im = e;
        in_valid_f = 1'b1;
        wait_ov(1'b1, lat);
        check({tag, "_lat"}, 64'(lat), ez ? 64'd2 : 64'd83);
        check({tag, "_re"}, 64'(qre_f), 64'(er));
        check({tag, "_im"}, 64'(qim_f), 64'(ei));
        check({tag, "_dbz"}, 64'(dbz_f), 64'(ez));
        @(negedge clk);
        out_ready_f = 1'b1;
        @(posedge clk);
        #1;
        out_ready_f = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op(input int mode);
        logic [31:0] x;
        x = (mode == 0) ? 32'($urandom_range(0, 16)) - 32'd8 : 32'($urandom);
        if (mode == 2 && $urandom_range(0, 1) == 1) x = 32'h8000_0000;
        return x;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] er1, ei1, er2, ei2;
        bit          ez;
        int          lat;
        #2 rst = 1'b1;
        #1;
        check("rst_ctl", 64'({in_ready, out_valid}), 64'b10);
        check("rst_q", 64'({quot_re, quot_im}), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run(32'd10, 32'd5, 32'd1, 32'd2, "basic");
        check("basic_re_k", 64'(quot_re), 64'd4);
        check("basic_im_k", 64'(quot_im), 64'hFFFF_FFFD);
        run(32'd7, 32'd0, 32'd2, 32'd0, "trunc_pos");
        check("trunc_pos_k", 64'(quot_re), 64'd3);
        run(-32'sd7, 32'd0, 32'd2, 32'd0, "trunc_neg");
        check("trunc_neg_k", 64'(quot_re), 64'hFFFF_FFFD);
        run(32'd0, 32'd9, 32'd0, 32'd3, "imag");
        check("imag_k", 64'({quot_re, quot_im}), {32'd3, 32'd0});

        run(32'd123, 32'd45, 32'd0, 32'd0, "dbz");
        check("dbz_hold", 64'({div_by_zero, quot_re, quot_im}), {1'b1, 64'd0});
        run(32'd7, 32'd0, 32'd2, 32'd0, "dbz_clr");
        check("dbz_clr_k", 64'(div_by_zero), 64'd0);

        run(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, "minneg");
        run(32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd0, "minneg_wrap");
        check("minneg_wrap_k", 64'(quot_re), 64'h8000_0000);

        for (int i = 0; i < 24; i++) begin
            int m;
            m = $urandom_range(0, 2);
            run(rnd_op(m), rnd_op(m), rnd_op(m), rnd_op(m), "rnd");
        end

        run_f(32'h0001_0000, 32'd0, 32'd0, 32'h0002_0000, "frac");
        check("frac_k", 64'({qre_f, qim_f}), {32'd0, 32'hFFFF_8000});
        for (int i = 0; i < 4; i++)
            run_f(rnd_op(0), rnd_op(0), rnd_op(0), rnd_op(0), "frac_rnd");

        model(32'd37, -32'sd11, 32'd3, 32'd4, 0, er1, ei1, ez);
        model(32'd100, 32'd50, -32'sd7, 32'd2, 0, er2, ei2, ez);
        @(negedge clk);
        num_re = 32'd37; num_im = -32'sd11; den_re = 32'd3; den_im = 32'd4;
        in_valid = 1'b1;
        wait_ov(1'b0, lat);
        check("bp_lat", 64'(lat), 64'd67);
        @(negedge clk);
        num_re = 32'd100; num_im = 32'd50; den_re = -32'sd7; den_im = 32'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("bp_ctl", 64'({out_valid, in_ready}), 64'b10);
            check("bp_q", 64'({quot_re, quot_im}), {er1, ei1});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_ack", 64'({in_ready, out_valid}), 64'b10);
        wait_ov(1'b0, lat);
        check("bp_q2_lat", 64'(lat), 64'd67);
        check("bp_q2", 64'({quot_re, quot_im}), {er2, ei2});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        @(negedge clk);
        num_re = 32'd10; num_im = 32'd5; den_re = 32'd1; den_im = 32'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (31) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ctl", 64'({in_ready, out_valid}), 64'b10);
        check("mid_rst_q", 64'({quot_re, quot_im}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run(32'd10, 32'd5, 32'd1, 32'd2, "post_rst");
        check("post_rst_k", 64'({quot_re, quot_im}), {32'd4, 32'hFFFF_FFFD});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
